// File: rtl/intersection_sequencer.sv
// Round-robin green-phase sequencer: grants one approach at a time, waits for its done pulse,
// then holds all-red for CLEAR_CYCLES clocks. Optional demand skipping: INTERSECTION_SEQUENCER_DEMAND_SKIP_EN.
module intersection_sequencer #(
    parameter int N_APPROACH   = 4,
    parameter int CLEAR_CYCLES = 3,
    parameter int TIMEOUT      = 200,
    localparam int IW          = (N_APPROACH > 1) ? $clog2(N_APPROACH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_APPROACH-1:0] done,
    input  logic [N_APPROACH-1:0] demand,
    output logic [N_APPROACH-1:0] go,
    output logic                  all_red,
    output logic [IW-1:0]         active_idx,
    output logic                  fault,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {START, GRANT, CLEAR, FAULT} state_t;

    localparam logic [3:0] CLR_LOAD = 4'(CLEAR_CYCLES - 1);
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [IW-1:0] idx_n;
    logic [3:0]    clr_cnt, cnt_n;
    logic [7:0]    wd, wd_n;
    logic          sel_found;
    logic [IW-1:0] sel_idx;

`ifdef INTERSECTION_SEQUENCER_DEMAND_SKIP_EN
    // Round-robin search; walk offsets downward so the nearest requester wins.
    always_comb begin
        int base_i;
        int j;
        base_i    = (state == START) ? 0 : int'(active_idx) + 1;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = N_APPROACH - 1; off >= 0; off--) begin
            j = (base_i + off) % N_APPROACH;
            if (demand[j]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
            end
        end
    end
`else
    logic unused_demand;
    assign unused_demand = ^demand;

    always_comb begin
        sel_found = 1'b1;
        if (state == START)
            sel_idx = '0;
        else if (active_idx == IW'(N_APPROACH - 1))
            sel_idx = '0;
        else
            sel_idx = active_idx + IW'(1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= START;
            active_idx <= '0;
            clr_cnt    <= '0;
            wd         <= '0;
        end else begin
            state      <= state_n;
            active_idx <= idx_n;
            clr_cnt    <= cnt_n;
            wd         <= wd_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = active_idx;
        cnt_n   = clr_cnt;
        wd_n    = wd;
        case (state)
            START: begin
                if (sel_found) begin
                    state_n = GRANT;
                    idx_n   = sel_idx;
                    wd_n    = '0;
                end
            end
            GRANT: begin
                wd_n = wd + 8'd1;
                // done beats a watchdog expiry in the same cycle
                if (done[active_idx]) begin
                    state_n = CLEAR;
                    cnt_n   = CLR_LOAD;
                end else if (wd == WD_LAST) begin
                    state_n = FAULT;
                end
            end
            CLEAR: begin
                if (clr_cnt != 4'd0) begin
                    cnt_n = clr_cnt - 4'd1;
                end else if (sel_found) begin
                    state_n = GRANT;
                    idx_n   = sel_idx;
                    wd_n    = '0;
                end
            end
            FAULT: state_n = FAULT;
            default: state_n = START;
        endcase
    end

    always_comb begin
        go = '0;
        if (state == GRANT)
            go[active_idx] = 1'b1;
    end

    assign all_red   = (state != GRANT);
    assign fault     = (state == FAULT);
    assign state_dbg = state;

endmodule

// File: doc/intersection_sequencer.md
# intersection_sequencer

Round-robin phase sequencer for a multi-approach intersection. It grants the green cycle to one approach light controller at a time by driving that controller's enable level. It waits for the controller's end-of-cycle `next` pulse, then inserts an all-red clearance interval before granting the following approach. It sits above the per-approach light counters and is the consumer end of their `next` handshake. It also drives their sensor/enable input.

## Interface
Parameters:
- `N_APPROACH`, 4: number of approaches; legal range 2..8.
- `CLEAR_CYCLES`, 3: all-red clearance length in clocks; legal range 1..15.
- `TIMEOUT`, 200: maximum clocks a grant may last without `done`; legal range 2..255.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `done`, input, N_APPROACH: per-approach end-of-cycle pulse (the controllers' `next`); one bit per approach.
- `demand`, input, N_APPROACH: per-approach vehicle-present level. Used only with `DEMAND_SKIP_EN`.
- `go`, output, N_APPROACH: one-hot or zero grant level to the approach controllers.
- `all_red`, output, 1: high whenever no approach is granted.
- `active_idx`, output, clog2(N_APPROACH): index of the current or most recent grant.
- `fault`, output, 1: sticky watchdog fault.

## Operation
- States: `START`, `GRANT`, `CLEAR`, `FAULT`.
- Reset values: state `START`, `go`=0, `all_red`=1, `active_idx`=0, `fault`=0, clearance counter 0, watchdog 0.
- `START`:
  - Unconditionally moves to `GRANT` with `active_idx`=0 on the first clock edge after reset deassertion.
  - With `DEMAND_SKIP_EN`, uses the same selection rule as `CLEAR` exit, with the search starting at index 0 inclusive.
- `GRANT`:
  - `go[active_idx]`=1, all other `go` bits 0, `all_red`=0.
  - Only `done[active_idx]` is honoured; other `done` bits are ignored.
  - On `done[active_idx]`=1: go to `CLEAR` and load the clearance counter with `CLEAR_CYCLES`-1.
- `CLEAR`:
  - `go`=0, `all_red`=1.
  - Counter decrements each clock.
  - At counter 0: select the next index, go to `GRANT`, and clear the watchdog.
- Next index without `DEMAND_SKIP_EN`: (`active_idx`+1) mod `N_APPROACH`.
- Watchdog:
  - 8-bit counter, incremented every clock in `GRANT`.
  - If it equals `TIMEOUT`-1 and `done[active_idx]`=0: go to `FAULT`.
- `FAULT`: `go`=0, `all_red`=1, `fault`=1. Held until reset.
- Boundary conditions:
  - `done[active_idx]` in the same cycle as watchdog expiry: `done` wins, go to `CLEAR`.
  - `done` asserted in `START`, `CLEAR` or `FAULT`: ignored, not latched.
  - A `done` held high for several cycles counts as one event; re-grant always passes through `CLEAR`.
  - Reset mid-operation forces all outputs to reset values immediately (asynchronously).
  - `go` is never multi-hot. `go` and `all_red` are mutually exclusive, and exactly one is non-zero at all times.

## Timing
- All outputs are registered from state.
- `done` sampled at edge k: `go` drops and `all_red` rises after edge k.
- The next `go` rises after edge k+`CLEAR_CYCLES`, giving exactly `CLEAR_CYCLES` all-red cycles.
- First grant: `go[0]` is high from the first edge after reset release.
- Maximum grant length: `TIMEOUT` cycles. `fault` rises after the edge ending cycle `TIMEOUT`.
- `active_idx` updates on the same edge `go` rises.
- `active_idx` holds its value through `CLEAR` and `FAULT`.

## Configuration
- Macro: `INTERSECTION_SEQUENCER_DEMAND_SKIP_EN`.
- Defined, at `CLEAR` exit:
  - `demand` is sampled.
  - The next index is the first i with `demand[i]`=1, searching in round-robin order from `active_idx`+1 and wrapping to include `active_idx` last.
  - If no `demand` bit is set, remain in `CLEAR` with the counter held at 0 and `all_red`=1. Re-evaluate every clock.
- Not defined: the `demand` port exists but is ignored, and the rotation is strict.

## Test plan
- Reset release, N=4, CLEAR=3: `go`=0001 the first cycle; `done[0]` pulse -> 3 cycles `all_red`=1, then `go`=0010 and `active_idx`=1.
- Full rotation: pulse `done` at indices 0,1,2,3 -> grants 0,1,2,3,0; the wrap returns to index 0 with exactly 3 clearance cycles each time.
- Spurious `done`: `done`=1110 during grant 0, and `done` pulses during `CLEAR` -> no state change; `go` stays 0001.
- Watchdog, TIMEOUT=10: no `done` for 10 cycles -> `fault`=1, `go`=0, `all_red`=1 held; `done[0]` at cycle 10 instead -> no fault.
- Async reset mid-`GRANT` index 2 -> `go`=0, `all_red`=1 and `active_idx`=0 immediately, then `go`=0001 after release.
- `DEMAND_SKIP_EN`:
  - `demand`=0100 at `CLEAR` exit from index 0 -> `go`=0100.
  - `demand`=0000 -> `all_red` held until `demand`=0001 -> `go`=0001 the next cycle.
